// File: rtl/fifo10_token_source.sv
// Enqueue-side controller for a depth-1 token FIFO.
// Issues a counted burst of ENQ strobes, with abort/clear and stall detection.
module fifo10_token_source #(
  parameter int CW          = 8,
  parameter int STALL_LIMIT = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [CW-1:0] i_count,
  input  logic          i_abort,
  input  logic          i_full_n,
  output logic          o_enq,
  output logic          o_clr,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [CW-1:0] o_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_ERR,
    S_FIN
  } state_t;

  localparam logic [15:0]   LP_LIMIT = 16'(STALL_LIMIT);
  localparam logic [CW-1:0] LP_ONE   = CW'(1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_remaining;
  logic [CW-1:0] w_remaining;
  logic [CW-1:0] r_sent;
  logic [CW-1:0] w_sent;
  logic [15:0]   r_stall;
  logic [15:0]   w_stall;
  logic [15:0]   w_stall_inc;
  logic          r_clr;
  logic          w_enq;

  assign w_stall_inc = r_stall + 16'd1;

  always_comb begin
    w_next      = r_state;
    w_remaining = r_remaining;
    w_sent      = r_sent;
    w_stall     = r_stall;
    w_enq       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_sent = '0;
          if (i_count != '0) begin
            w_next      = S_RUN;
            w_remaining = i_count;
            w_stall     = '0;
          end else begin
            w_next = S_FIN;
          end
        end
      end
      S_RUN: begin
        // Abort outranks both the enqueue and the stall escalation.
        if (i_abort) begin
          w_next = S_FLUSH;
        end else if (i_full_n) begin
          w_enq       = 1'b1;
          w_remaining = r_remaining - LP_ONE;
          w_sent      = r_sent + LP_ONE;
          w_stall     = '0;
          if (r_remaining == LP_ONE) w_next = S_FIN;
        end else begin
          w_stall = w_stall_inc;
          if (w_stall_inc == LP_LIMIT) w_next = S_ERR;
        end
      end
      S_ERR: begin
        if (i_abort) w_next = S_FLUSH;
      end
      S_FLUSH: w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_sent      <= '0;
      r_stall     <= '0;
      r_clr       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_remaining <= w_remaining;
      r_sent      <= w_sent;
      r_stall     <= w_stall;
      r_clr       <= (w_next == S_FLUSH);
    end
  end

  assign o_enq   = w_enq;
  assign o_clr   = r_clr;
  assign o_busy  = (r_state == S_RUN) || (r_state == S_ERR) ||
                   (r_state == S_FLUSH);
  assign o_done  = (r_state == S_FIN);
  assign o_error = (r_state == S_ERR);
  assign o_sent  = r_sent;

endmodule

// File: tb/tb_fifo10_token_source.sv
// Directed bench for fifo10_token_source.
// Inputs change 1ns after posedge; outputs sampled 4ns later.
module tb_fifo10_token_source;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] count;
  logic       abort;
  logic       full_n;
  logic       enq;
  logic       clr;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] sent;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo10_token_source #(.CW(8), .STALL_LIMIT(16)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_count (count),
    .i_abort (abort),
    .i_full_n(full_n),
    .o_enq   (enq),
    .o_clr   (clr),
    .o_busy  (busy),
    .o_done  (done),
    .o_error (error),
    .o_sent  (sent)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #4;
  endtask

  initial begin
    int npulse;
    int ncyc;
    int bad;

    rst = 1'b1; start = 0; count = 0; abort = 0; full_n = 1;
    #2;
    chk("rst_enq", enq, 0);
    chk("rst_clr", clr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_sent", sent, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Burst of 3 with FIFO always ready
    start = 1; count = 3; full_n = 1;
    smp();
    chk("t1_idle_enq", enq, 0);
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t1_enq", enq, 1);
      chk("t1_busy", busy, 1);
      tick();
    end
    smp();
    chk("t1_done", done, 1);
    chk("t1_sent", sent, 3);
    chk("t1_busy_lo", busy, 0);
    chk("t1_enq_lo", enq, 0);
    tick();
    smp();
    chk("t1_done_lo", done, 0);
    tick();

    // Burst of 4 with FULL_N alternating 1,0,...
    start = 1; count = 4;
    tick();
    start = 0;
    npulse = 0; ncyc = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      full_n = (i % 2 == 0);
      smp();
      if (done) break;
      if (enq) npulse++;
      if (enq && !full_n) bad++;
      if (error) bad++;
      ncyc++;
      tick();
    end
    chk("t2_pulses", npulse, 4);
    chk("t2_cycles", ncyc, 7);
    chk("t2_bad", bad, 0);
    chk("t2_done", done, 1);
    chk("t2_sent", sent, 4);
    tick();
    tick();

    // Stall into ERR, then abort out
    start = 1; count = 2; full_n = 1;
    tick();
    start = 0;
    smp();
    chk("t3_enq1", enq, 1);
    tick();
    full_n = 0;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      smp();
      if (error || enq) bad++;
      tick();
    end
    chk("t3_pre_err", bad, 0);
    smp();
    chk("t3_err", error, 1);
    chk("t3_sent1", sent, 1);
    tick();
    full_n = 1;
    smp();
    chk("t3_err_noenq", enq, 0);
    chk("t3_err_hold", error, 1);
    tick();
    abort = 1;
    smp();
    chk("t3_abort_noclr", clr, 0);
    tick();
    abort = 0;
    smp();
    chk("t3_clr", clr, 1);
    chk("t3_flush_busy", busy, 1);
    chk("t3_flush_enq", enq, 0);
    tick();
    smp();
    chk("t3_done", done, 1);
    chk("t3_clr_lo", clr, 0);
    chk("t3_sent", sent, 1);
    tick();
    tick();

    // Abort coincident with third eligible ENQ
    start = 1; count = 5; full_n = 1;
    tick();
    start = 0;
    smp(); chk("t4_enq_a", enq, 1); tick();
    smp(); chk("t4_enq_b", enq, 1); tick();
    abort = 1;
    smp();
    chk("t4_abort_enq", enq, 0);
    tick();
    abort = 0;
    smp();
    chk("t4_clr", clr, 1);
    chk("t4_sent", sent, 2);
    chk("t4_flush_enq", enq, 0);
    tick();
    smp();
    chk("t4_done", done, 1);
    chk("t4_fin_enq", enq, 0);
    tick();
    smp();
    chk("t4_idle_enq", enq, 0);
    tick();

    // COUNT=0, then START ignored while busy
    start = 1; count = 0;
    tick();
    start = 0;
    smp();
    chk("t5_done", done, 1);
    chk("t5_sent", sent, 0);
    chk("t5_enq", enq, 0);
    tick();
    start = 1; count = 2;
    tick();
    start = 1; count = 9;
    smp(); chk("t5_enq_a", enq, 1); tick();
    start = 0;
    smp(); chk("t5_enq_b", enq, 1); tick();
    smp();
    chk("t5_done2", done, 1);
    chk("t5_sent2", sent, 2);
    tick();
    tick();

    // Reset mid-burst
    start = 1; count = 6;
    tick();
    start = 0;
    tick(); tick();
    smp();
    chk("t6_pre_sent", sent, 2);
    tick();
    rst = 1;
    #1;
    chk("t6_enq", enq, 0);
    chk("t6_clr", clr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_sent", sent, 0);
    chk("t6_done", done, 0);
    tick();
    rst = 0;
    tick();
    start = 1; count = 1;
    tick();
    start = 0;
    smp();
    chk("t6_enq1", enq, 1);
    tick();
    smp();
    chk("t6_done1", done, 1);
    chk("t6_sent1", sent, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
